bpf_alu_seq: RTL and testbench

Parametrised, handshaked ALU for the BPF datapath. It supersedes the old 8-bit combinational ALU: the same operand/op/result roles, generalised width, and an extended opcode set with eBPF semantics. Results are registered. Divide and modulo run on an iterative restoring divider, one quotient bit per cycle. The block sits between the register-file read stage and write-back, and uses valid/ready handshakes on both sides.

---
 rtl/bpf_alu_seq.sv | 184 ++++++++++++++++++
 tb/tb_bpf_alu_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bpf_alu_seq.sv
// bpf_alu_seq: handshaked, result-registered ALU for the BPF datapath.
// Single-cycle ops (mov/add/sub/mul/and/or/not/xor/lsh/rsh/neg) produce a
// result one edge after acceptance.  div/mod with a non-zero divisor run on
// an iterative restoring divider, one quotient bit per cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operation presented on i1/i2/op
//   in_ready   operation accepted this cycle when in_valid is also high
//   i1, i2     operands (dst, src), WIDTH bits, unsigned
//   op         opcode (0 mov .. 12 neg, 13-15 reserved)
//   out_valid  o/dz hold a result
//   out_ready  consumer takes the result this cycle
//   o          result
//   dz         result came from div/mod with i2 == 0
//
// state | meaning
// ------+----------------------------------
// IDLE  | no result pending
// BUSY  | divider iterating
// HOLD  | result pending on o/dz, out_valid = 1

module bpf_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             dz
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_LSH = 4'd9;
    localparam logic [3:0] OP_RSH = 4'd10;
    localparam logic [3:0] OP_MOD = 4'd11;
    localparam logic [3:0] OP_NEG = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_d;

    // Divider registers: dvd shifts out dividend bits from the top and
    // collects quotient bits at the bottom, so it ends up holding the quotient.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             is_mod;
    logic [SHW-1:0]   cnt;

    logic             accept;
    logic             div_start;
    logic             last_step;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] alu_o;
    logic             alu_dz;

    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    assign in_ready  = (state == IDLE) || (state == HOLD && out_ready);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign div_start = ((op == OP_DIV) || (op == OP_MOD)) && (i2 != '0);
    assign last_step = (cnt == SHW'(WIDTH - 1));
    assign sh_amt    = i2[SHW-1:0];

    // One restoring step.  The shifted remainder needs WIDTH+1 bits because
    // rem can be as large as divisor-1 before the shift.  When the compare
    // succeeds the difference is below the divisor, so the low WIDTH bits
    // of the subtraction are exact.
    assign rem_sh = {rem, dvd[WIDTH-1]};
    assign rem_ge = (rem_sh >= {1'b0, dvs});
    assign rem_nx = rem_ge ? (rem_sh[WIDTH-1:0] - dvs) : rem_sh[WIDTH-1:0];
    assign quo_nx = {dvd[WIDTH-2:0], rem_ge};

    always_comb begin
        alu_o  = '0;
        alu_dz = 1'b0;
        case (op)
            OP_MOV: alu_o = i2;
            OP_ADD: alu_o = i1 + i2;
            OP_SUB: alu_o = i1 - i2;
            OP_MUL: alu_o = i1 * i2;
            OP_AND: alu_o = i1 & i2;
            OP_OR:  alu_o = i1 | i2;
            OP_NOT: alu_o = ~i1;
            OP_XOR: alu_o = i1 ^ i2;
            OP_LSH: alu_o = i1 << sh_amt;
            OP_RSH: alu_o = i1 >> sh_amt;
            OP_NEG: alu_o = '0 - i1;
            // Only reached as single-cycle ops when the divisor is zero.
            OP_DIV: begin
                alu_o  = '0;
                alu_dz = 1'b1;
            end
            OP_MOD: begin
                alu_o  = i1;
                alu_dz = 1'b1;
            end
            default: begin
                alu_o  = '0;
                alu_dz = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) state_d = div_start ? BUSY : HOLD;
            end
            BUSY: begin
                if (last_step) state_d = HOLD;
            end
            HOLD: begin
                if (accept)         state_d = div_start ? BUSY : HOLD;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o      <= '0;
            dz     <= 1'b0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            is_mod <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            if (div_start) begin
                dvd    <= i1;
                dvs    <= i2;
                rem    <= '0;
                is_mod <= (op == OP_MOD);
                cnt    <= '0;
            end else begin
                o  <= alu_o;
                dz <= alu_dz;
            end
        end else if (state == BUSY) begin
            dvd <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt + SHW'(1);
            if (last_step) begin
                o  <= is_mod ? rem_nx : quo_nx;
                dz <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bpf_alu_seq.sv
// Directed, table-driven bench for bpf_alu_seq (WIDTH = 32).
module tb_bpf_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] o;
    logic        dz;

    int checks = 0;
    int errors = 0;

    bpf_alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i1        (i1),
        .i2        (i2),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  p;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eo;
        logic        edz;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one op from IDLE with out_ready high, wait (bounded) for the
    // result, check latency/result, and confirm it is consumed next edge.
    task automatic run_op(input logic [3:0] p, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eo, input logic edz, input int lat, input string nm);
        int n;
        logic busy_ok;
        in_valid  = 1'b1;
        op        = p;
        i1        = a;
        i2        = b;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        i1 = $urandom;
        i2 = $urandom;
        op = 4'($urandom);
        n = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check({nm, " latency"}, 32'(n), 32'(lat));
        check({nm, " busy in_ready"}, 32'(busy_ok), 32'd1);
        check({nm, " o"}, o, eo);
        check({nm, " dz"}, 32'(dz), 32'(edz));
        @(posedge clk); #1;
        check({nm, " consumed"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vecs.push_back('{4'd1,  32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 0,  "add wrap"});
        vecs.push_back('{4'd0,  32'h11111111, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0,  "mov"});
        vecs.push_back('{4'd2,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 0,  "sub wrap"});
        vecs.push_back('{4'd3,  32'h00010000, 32'h00010001, 32'h00010000, 1'b0, 0,  "mul low"});
        vecs.push_back('{4'd5,  32'hF0F0F0F0, 32'hFFFF0000, 32'hF0F00000, 1'b0, 0,  "and"});
        vecs.push_back('{4'd6,  32'hF0F0F0F0, 32'h0000FFFF, 32'hF0F0FFFF, 1'b0, 0,  "or"});
        vecs.push_back('{4'd7,  32'h0000FFFF, 32'h12345678, 32'hFFFF0000, 1'b0, 0,  "not"});
        vecs.push_back('{4'd10, 32'hF0000000, 32'hFFFFFFE4, 32'h0F000000, 1'b0, 0,  "rsh upper ignored"});
        vecs.push_back('{4'd4,  32'h00001234, 32'd0,        32'h00000000, 1'b1, 0,  "div by zero"});
        vecs.push_back('{4'd11, 32'h00001234, 32'd0,        32'h00001234, 1'b1, 0,  "mod by zero"});
        vecs.push_back('{4'd13, 32'h12345678, 32'h1,        32'h00000000, 1'b0, 0,  "reserved 13"});
        vecs.push_back('{4'd15, 32'hFFFFFFFF, 32'h5,        32'h00000000, 1'b0, 0,  "reserved 15"});
        vecs.push_back('{4'd4,  32'd100,      32'd7,        32'd14,       1'b0, 32, "div 100/7"});
        vecs.push_back('{4'd11, 32'd100,      32'd7,        32'd2,        1'b0, 32, "mod 100%7"});
        vecs.push_back('{4'd4,  32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 1'b0, 32, "div big"});
        vecs.push_back('{4'd11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 1'b0, 32, "mod big"});
        vecs.push_back('{4'd4,  32'd5,        32'd9,        32'd0,        1'b0, 32, "div small"});
        vecs.push_back('{4'd11, 32'd5,        32'd9,        32'd5,        1'b0, 32, "mod small"});
        vecs.push_back('{4'd4,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0, 32, "div max/max"});

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        i1        = '0;
        i2        = '0;
        op        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset o", o, 32'd0);
        check("reset dz", 32'(dz), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        // No accept while rst is high.
        in_valid = 1'b1; op = 4'd1; i1 = 32'd1; i2 = 32'd1;
        @(posedge clk); #1;
        check("no accept in reset", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[k])
            run_op(vecs[k].p, vecs[k].a, vecs[k].b, vecs[k].eo, vecs[k].edz, vecs[k].lat, vecs[k].nm);

        // Back-to-back stream, no bubbles.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = 4'd8;  i1 = 32'hF0F0F0F0; i2 = 32'hFFFF0000;
        @(posedge clk); #1;
        check("stream xor valid", 32'(out_valid), 32'd1);
        check("stream xor o", o, 32'h0F0FF0F0);
        op = 4'd9;  i1 = 32'd1; i2 = 32'd35;
        @(posedge clk); #1;
        check("stream lsh valid", 32'(out_valid), 32'd1);
        check("stream lsh o", o, 32'h00000008);
        op = 4'd10; i1 = 32'h80000000; i2 = 32'd31;
        @(posedge clk); #1;
        check("stream rsh valid", 32'(out_valid), 32'd1);
        check("stream rsh o", o, 32'h00000001);
        op = 4'd12; i1 = 32'd1; i2 = 32'd0;
        @(posedge clk); #1;
        check("stream neg valid", 32'(out_valid), 32'd1);
        check("stream neg o", o, 32'hFFFFFFFF);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("stream drained", 32'(out_valid), 32'd0);

        // Backpressure: result and in_ready stable while out_ready is low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 4'd3; i1 = 32'h00010000; i2 = 32'h00010001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        i1 = 32'hAAAAAAAA; i2 = 32'h55555555;
        for (int c = 0; c < 5; c++) begin
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp o", o, 32'h00010000);
            check("bp in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("bp o after", o, 32'h00010000);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = 4'd1; i1 = 32'd2; i2 = 32'd3;
        #1;
        check("bp in_ready on release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp next valid", 32'(out_valid), 32'd1);
        check("bp next o", o, 32'd5);
        @(posedge clk); #1;
        check("bp next consumed", 32'(out_valid), 32'd0);

        // Mod by zero leaves dz = 1 so the reset check below is meaningful.
        run_op(4'd11, 32'h00000077, 32'd0, 32'h00000077, 1'b1, 0, "mod0 pre-reset");

        // Reset mid-divide.
        in_valid = 1'b1;
        op = 4'd4; i1 = 32'd100; i2 = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid-div busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid-div rst out_valid", 32'(out_valid), 32'd0);
        check("mid-div rst o", o, 32'd0);
        check("mid-div rst dz", 32'(dz), 32'd0);
        check("mid-div rst in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);
        check("post-rst out_valid", 32'(out_valid), 32'd0);
        run_op(4'd1, 32'd2, 32'd3, 32'd5, 1'b0, 0, "post-rst add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
